pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Next-PC controller for the single-cycle/pipelined MIPS core; drives the program counter's write-enable and next-value (pc_if WEN/pci) and reads back its current value (pco).
- Selects among sequential PC+4, branch, jump and jump-register targets.
- Gates PC updates on instruction-memory hit and hazard stall, buffers one redirect that arrives while the PC is blocked, and freezes fetch on halt.

Parameters:
- PC_INIT, 32'h0000_0000, value presented on pc_next while in reset and BOOT.
- WORD_W, 32, datapath word width; must equal word_t width.

Ports:
- CLK  in  1  core clock.
- RST  in  1  synchronous active-high reset.
- pco  in  WORD_W  current PC from pc_if.
- ihit  in  1  instruction memory returned data this cycle.
- stall  in  1  hazard unit blocks PC advance.
- halt  in  1  halt instruction decoded.
- redir_valid  in  1  control-flow redirect request this cycle.
- redir_sel  in  2  pcsel_t: PCS_BR=1, PCS_J=2, PCS_JR=3 (0 = none, treated as no redirect).
- br_base  in  WORD_W  PC+4 of the redirecting instruction.
- imm16  in  16  branch offset.
- jaddr26  in  26  jump index.
- rs_data  in  WORD_W  register value for JR.
- pc_wen  out  1  to pc_if WEN.
- pc_next  out  WORD_W  to pc_if pci.
- imem_ren  out  1  instruction fetch request.
- halted  out  1  core halted.

Behaviour:
- State machine:
  - States BOOT, RUN, HALT; RST in any state forces BOOT.
  - BOOT lasts one cycle, then always goes to RUN.
  - RUN goes to HALT when halt=1 and the halting instruction's update is accepted (ihit=1 & stall=0); otherwise stays in RUN.
  - HALT is sticky until RST.
- Reset values, held in BOOT:
  - pc_wen=0, pc_next=PC_INIT, imem_ren=0, halted=0.
  - pend_valid=0, pend_target=0.
- Target arithmetic, purely combinational:
  - BR: br_base + (sign_extend(imm16) << 2), mod 2^32, wrap allowed.
  - J: {br_base[31:28], jaddr26, 2'b00}.
  - JR: rs_data unmodified.
- RUN outputs:
  - imem_ren=1.
  - pc_wen = ihit & ~stall & ~halt; the PC loads pc_next at the clock edge, so latency is 0 cycles.
- pc_next priority: pend_valid → pend_target; else redir_valid with a nonzero sel → computed target; else pco+4.
- Pending buffer:
  - Set on redir_valid while pc_wen=0 and pend_valid=0; captures the computed target.
  - Cleared on the first cycle with pc_wen=1.
- A redirect arriving while pend_valid=1 is dropped: the older redirect wins.
- If redir_valid arrives in the same cycle that pend_valid is consumed, the new redirect is dropped. The redirecting stage must hold redir_valid until it sees pc_wen with pend_valid=0.
- Halt:
  - halt with pc_wen blocked stays in RUN with pc_wen=0; it takes effect on the next accepted cycle.
  - halt overrides any simultaneous redirect and clears pend_valid.
- HALT state: pc_wen=0, imem_ren=0, halted=1; pc_next holds its last value; all inputs are ignored.
- Reset mid-operation discards the pending redirect with no write to the PC.
- pco+4 wraps 32'hFFFF_FFFC → 32'h0000_0000.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- Defined:
  - Adds output ports fetch_cnt[31:0] and stall_cnt[31:0].
  - fetch_cnt increments on each pc_wen=1 cycle.
  - stall_cnt increments on each RUN cycle with pc_wen=0 and halt=0.
  - Both reset to 0, saturate at 32'hFFFF_FFFF and freeze in HALT.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg: pcsel_t enum (PCS_NONE/BR/J/JR), the pcseq_state_t enum, and a PC_STEP=4 constant.
- Sub-module: pc_target_calc, the combinational BR/J/JR target mux, instantiated once.

Test Plan:
- Reset release, ihit=1, stall=0, pco=0:
  - First cycle after RST drop (BOOT): pc_wen=0, imem_ren=0.
  - Next cycle: pc_wen=1, pc_next=32'h4.
- BR redirect: br_base=32'h100, imm16=16'hFFFE, ihit=1 → pc_next=32'hF8, pc_wen=1 in the same cycle.
- J redirect: br_base=32'hA000_0010, jaddr26=26'h40 → pc_next=32'hA000_0100.
- Redirect JR (rs_data=32'h400) while stall=1 for 3 cycles, then stall=0:
  - pc_wen=0 during the stall and pend_valid=1.
  - On release, pc_next=32'h400 and pend_valid clears.
  - A second redirect presented during the stall is ignored.
- Halt with simultaneous BR redirect, ihit=1:
  - pc_wen=0 and the state goes to HALT.
  - Next cycle halted=1, imem_ren=0; stays there until RST, then BOOT.
- PC_SEQ_PERF_EN build: 5 fetches and 2 stall cycles → fetch_cnt=5, stall_cnt=2; values hold after halt.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared types for the MIPS fetch front end: PC-select codes,
//               sequencer state encoding, the sequential PC step and a branch
//               offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  // Redirect source; PCS_NONE is treated as "no redirect"
  typedef enum logic [1:0] {
    PCS_NONE = 2'd0,
    PCS_BR   = 2'd1,
    PCS_J    = 2'd2,
    PCS_JR   = 2'd3
  } pcsel_t;

  // Next-PC sequencer states
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pcseq_state_t;

  localparam word_t PC_STEP = 32'd4;

  // Sign-extend a 16-bit branch offset and convert words to bytes
  function automatic word_t br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Bundle between the core datapath (master) and the next-PC
//               sequencer (slave). The fetch/stall counters only exist when
//               PC_SEQ_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int WORD_W = 32
) ();

  // Datapath to sequencer
  logic [WORD_W-1:0] pco;
  logic              ihit;
  logic              stall;
  logic              halt;
  logic              redir_valid;
  logic [1:0]        redir_sel;
  logic [WORD_W-1:0] br_base;
  logic [15:0]       imm16;
  logic [25:0]       jaddr26;
  logic [WORD_W-1:0] rs_data;

  // Sequencer to datapath
  logic              pc_wen;
  logic [WORD_W-1:0] pc_next;
  logic              imem_ren;
  logic              halted;
`ifdef PC_SEQ_PERF_EN
  logic [31:0]       fetch_cnt;
  logic [31:0]       stall_cnt;
`endif

  modport master (
    output pco, ihit, stall, halt, redir_valid, redir_sel,
           br_base, imm16, jaddr26, rs_data,
`ifdef PC_SEQ_PERF_EN
    input  fetch_cnt, stall_cnt,
`endif
    input  pc_wen, pc_next, imem_ren, halted
  );

  modport slave (
    input  pco, ihit, stall, halt, redir_valid, redir_sel,
           br_base, imm16, jaddr26, rs_data,
`ifdef PC_SEQ_PERF_EN
    output fetch_cnt, stall_cnt,
`endif
    output pc_wen, pc_next, imem_ren, halted
  );

endinterface
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_calc
// Description : Combinational redirect target mux.
//               BR : br_base + sext(imm16)<<2 (wraps mod 2^32)
//               J  : {br_base[31:28], jaddr26, 2'b00}
//               JR : rs_data
// Revision    : 1.0 - initial release
// ============================================================================
module pc_target_calc
  import cpu_types_pkg::*;
(
  input  pcsel_t      sel_i,
  input  word_t       br_base_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] jaddr26_i,
  input  word_t       rs_data_i,
  output word_t       target_o
);

  // Select the target for the requested redirect kind
  always_comb begin
    target_o = br_base_i;
    case (sel_i)
      PCS_BR:  target_o = br_base_i + br_offset(imm16_i);
      PCS_J:   target_o = {br_base_i[31:28], jaddr26_i, 2'b00};
      PCS_JR:  target_o = rs_data_i;
      default: target_o = br_base_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Next-PC controller. Chooses PC+4 / branch / jump / JR target,
//               gates PC writes on ihit and stall, buffers one redirect that
//               arrives while the PC is blocked, and freezes fetch on halt.
//               Optional fetch/stall counters: define PC_SEQ_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import cpu_types_pkg::*;
#(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          RST,
  pc_sequencer_if.slave bus
);

  pcseq_state_t      state_q, state_d;
  pcseq_state_t      w_state;
  logic              pend_valid_q, pend_valid_d;
  logic [WORD_W-1:0] pend_target_q, pend_target_d;
  logic [WORD_W-1:0] last_next_q, last_next_d;

  pcsel_t            w_sel;
  word_t             w_target;
  logic              w_redir;
  logic              w_accept;
  logic              w_pc_wen;
  logic [WORD_W-1:0] w_pc_next;
  logic              w_imem_ren;
  logic              w_halted;

  assign w_sel    = pcsel_t'(bus.redir_sel);
  assign w_redir  = bus.redir_valid & (w_sel != PCS_NONE);
  assign w_accept = bus.ihit & ~bus.stall;

  // While RST is high the outputs already look like BOOT, so a reset
  // arriving mid-run never lets the PC be written in that cycle.
  assign w_state  = RST ? ST_BOOT : state_q;

  pc_target_calc u_target_calc (
    .sel_i     (w_sel),
    .br_base_i (bus.br_base),
    .imm16_i   (bus.imm16),
    .jaddr26_i (bus.jaddr26),
    .rs_data_i (bus.rs_data),
    .target_o  (w_target)
  );

  // State, pending-redirect and last-pc_next registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_BOOT;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      last_next_q   <= PC_INIT;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      last_next_q   <= last_next_d;
    end
  end

  // Next-state, pending-buffer update and output decode
  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    last_next_d   = last_next_q;
    w_pc_wen      = 1'b0;
    w_pc_next     = last_next_q;
    w_imem_ren    = 1'b0;
    w_halted      = 1'b0;

    case (w_state)
      ST_BOOT: begin
        w_pc_next     = PC_INIT;
        pend_valid_d  = 1'b0;
        pend_target_d = '0;
        last_next_d   = PC_INIT;
        state_d       = ST_RUN;
      end

      ST_RUN: begin
        w_imem_ren = 1'b1;
        w_pc_wen   = w_accept & ~bus.halt;

        // An older buffered redirect beats a live one; halt suppresses
        // any live redirect so the fall-through value is shown instead.
        if (pend_valid_q)
          w_pc_next = pend_target_q;
        else if (w_redir && !bus.halt)
          w_pc_next = w_target;
        else
          w_pc_next = bus.pco + PC_STEP;

        last_next_d = w_pc_next;

        // Pending buffer: halt flushes it, a PC write consumes it (and drops
        // any redirect in that same cycle), otherwise a blocked redirect is
        // captured only if the buffer is empty.
        if (bus.halt)
          pend_valid_d = 1'b0;
        else if (w_pc_wen)
          pend_valid_d = 1'b0;
        else if (w_redir && !pend_valid_q) begin
          pend_valid_d  = 1'b1;
          pend_target_d = w_target;
        end

        if (bus.halt && w_accept)
          state_d = ST_HALT;
      end

      ST_HALT: begin
        w_halted = 1'b1;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign bus.pc_wen   = w_pc_wen;
  assign bus.pc_next  = w_pc_next;
  assign bus.imem_ren = w_imem_ren;
  assign bus.halted   = w_halted;

`ifdef PC_SEQ_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        w_stall_cyc;

  assign w_stall_cyc = (w_state == ST_RUN) & ~w_pc_wen & ~bus.halt;

  // Saturating fetch and stall counters; both naturally freeze in HALT
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (w_pc_wen && (fetch_cnt_q != 32'hFFFF_FFFF))
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (w_stall_cyc && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt = fetch_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer. Counter checks
//               are included when PC_SEQ_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic CLK = 1'b0;
  logic RST;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  pc_sequencer_if #(.WORD_W(32)) bus ();

  pc_sequencer #(
    .WORD_W  (32),
    .PC_INIT (32'h0000_0000)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are then changed 2 time units after the edge
  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST             = 1'b1;
    bus.pco         = 32'h0;
    bus.ihit        = 1'b1;
    bus.stall       = 1'b0;
    bus.halt        = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_sel   = 2'd0;
    bus.br_base     = 32'h0;
    bus.imm16       = 16'h0;
    bus.jaddr26     = 26'h0;
    bus.rs_data     = 32'h0;

    // Held in reset
    repeat (3) next_cycle();
    #1;
    chk("rst_pc_wen",   {31'b0, bus.pc_wen},   32'h0);
    chk("rst_pc_next",  bus.pc_next,           32'h0);
    chk("rst_imem_ren", {31'b0, bus.imem_ren}, 32'h0);
    chk("rst_halted",   {31'b0, bus.halted},   32'h0);
`ifdef PC_SEQ_PERF_EN
    chk("rst_fetch_cnt", bus.fetch_cnt, 32'h0);
    chk("rst_stall_cnt", bus.stall_cnt, 32'h0);
`endif

    // Reset released: BOOT cycle
    RST = 1'b0;
    #1;
    chk("boot_pc_wen",   {31'b0, bus.pc_wen},   32'h0);
    chk("boot_imem_ren", {31'b0, bus.imem_ren}, 32'h0);
    chk("boot_pc_next",  bus.pc_next,           32'h0);

    // First RUN cycle: sequential fetch
    next_cycle();
    #1;
    chk("run_pc_wen",   {31'b0, bus.pc_wen},   32'h1);
    chk("run_pc_next",  bus.pc_next,           32'h4);
    chk("run_imem_ren", {31'b0, bus.imem_ren}, 32'h1);
    chk("run_halted",   {31'b0, bus.halted},   32'h0);

    // Branch with negative offset: 0x100 + (-2 << 2) = 0xF8
    next_cycle();
    bus.pco = 32'h4; bus.redir_valid = 1'b1; bus.redir_sel = 2'd1;
    bus.br_base = 32'h100; bus.imm16 = 16'hFFFE;
    #1;
    chk("br_pc_next", bus.pc_next,         32'h0000_00F8);
    chk("br_pc_wen",  {31'b0, bus.pc_wen}, 32'h1);

    // Jump: {0xA, 0x40<<2} = 0xA000_0100
    next_cycle();
    bus.pco = 32'hF8; bus.redir_sel = 2'd2;
    bus.br_base = 32'hA000_0010; bus.jaddr26 = 26'h40;
    #1;
    chk("j_pc_next", bus.pc_next, 32'hA000_0100);

    // Sequential after jump
    next_cycle();
    bus.pco = 32'hA000_0100; bus.redir_valid = 1'b0; bus.redir_sel = 2'd0;
    #1;
    chk("seq_pc_next", bus.pc_next, 32'hA000_0104);

    // PC+4 wrap-around
    next_cycle();
    bus.pco = 32'hFFFF_FFFC;
    #1;
    chk("wrap_pc_next", bus.pc_next,         32'h0);
    chk("wrap_pc_wen",  {31'b0, bus.pc_wen}, 32'h1);

    // JR while stalled: buffered
    next_cycle();
    bus.pco = 32'h200; bus.stall = 1'b1;
    bus.redir_valid = 1'b1; bus.redir_sel = 2'd3; bus.rs_data = 32'h400;
    #1;
    chk("jr_stall_pc_wen",  {31'b0, bus.pc_wen},       32'h0);
    chk("jr_stall_pc_next", bus.pc_next,               32'h400);
    chk("jr_stall_pend0",   {31'b0, dut.pend_valid_q}, 32'h0);

    // Second redirect during stall is ignored
    next_cycle();
    bus.redir_sel = 2'd1; bus.br_base = 32'h100; bus.imm16 = 16'hFFFE;
    #1;
    chk("stall2_pend",    {31'b0, dut.pend_valid_q}, 32'h1);
    chk("stall2_pc_wen",  {31'b0, bus.pc_wen},       32'h0);
    chk("stall2_pc_next", bus.pc_next,               32'h400);

    // Third stall cycle, no redirect
    next_cycle();
    bus.redir_valid = 1'b0; bus.redir_sel = 2'd0;
    #1;
    chk("stall3_pend",    {31'b0, dut.pend_valid_q}, 32'h1);
    chk("stall3_pc_next", bus.pc_next,               32'h400);

    // Release: buffered JR wins, a simultaneous J is dropped
    next_cycle();
    bus.stall = 1'b0; bus.redir_valid = 1'b1; bus.redir_sel = 2'd2;
    bus.br_base = 32'h100; bus.jaddr26 = 26'h40;
    #1;
    chk("rel_pc_wen",  {31'b0, bus.pc_wen}, 32'h1);
    chk("rel_pc_next", bus.pc_next,         32'h400);

    // Pending cleared, dropped J not replayed
    next_cycle();
    bus.pco = 32'h400; bus.redir_valid = 1'b0; bus.redir_sel = 2'd0;
    #1;
    chk("post_pend",    {31'b0, dut.pend_valid_q}, 32'h0);
    chk("post_pc_next", bus.pc_next,               32'h404);

    // Halt while blocked: stays in RUN
    next_cycle();
    bus.pco = 32'h404; bus.halt = 1'b1; bus.stall = 1'b1;
    #1;
    chk("hblk_pc_wen",   {31'b0, bus.pc_wen},   32'h0);
    chk("hblk_imem_ren", {31'b0, bus.imem_ren}, 32'h1);
    chk("hblk_pc_next",  bus.pc_next,           32'h408);

    // Halt accepted with simultaneous branch: branch overridden
    next_cycle();
    bus.stall = 1'b0; bus.redir_valid = 1'b1; bus.redir_sel = 2'd1;
    bus.br_base = 32'h100; bus.imm16 = 16'hFFFE;
    #1;
    chk("hacc_halted",  {31'b0, bus.halted}, 32'h0);
    chk("hacc_pc_wen",  {31'b0, bus.pc_wen}, 32'h0);
    chk("hacc_pc_next", bus.pc_next,         32'h408);

    // HALT state
    next_cycle();
    #1;
    chk("halt_halted",   {31'b0, bus.halted},   32'h1);
    chk("halt_imem_ren", {31'b0, bus.imem_ren}, 32'h0);
    chk("halt_pc_wen",   {31'b0, bus.pc_wen},   32'h0);
    chk("halt_pc_next",  bus.pc_next,           32'h408);
`ifdef PC_SEQ_PERF_EN
    chk("halt_fetch_cnt", bus.fetch_cnt, 32'd7);
    chk("halt_stall_cnt", bus.stall_cnt, 32'd3);
`endif

    // HALT ignores all inputs
    next_cycle();
    bus.halt = 1'b0; bus.redir_valid = 1'b1; bus.redir_sel = 2'd3;
    bus.rs_data = 32'h1234; bus.pco = 32'h800;
    #1;
    chk("halt2_halted",  {31'b0, bus.halted}, 32'h1);
    chk("halt2_pc_wen",  {31'b0, bus.pc_wen}, 32'h0);
    chk("halt2_pc_next", bus.pc_next,         32'h408);
    next_cycle();
    #1;
    chk("halt3_halted", {31'b0, bus.halted}, 32'h1);
`ifdef PC_SEQ_PERF_EN
    chk("halt3_fetch_cnt", bus.fetch_cnt, 32'd7);
    chk("halt3_stall_cnt", bus.stall_cnt, 32'd3);
`endif

    // Reset from HALT returns to BOOT
    RST = 1'b1;
    next_cycle();
    #1;
    chk("rst2_halted",   {31'b0, bus.halted},       32'h0);
    chk("rst2_pc_next",  bus.pc_next,               32'h0);
    chk("rst2_imem_ren", {31'b0, bus.imem_ren},     32'h0);
    chk("rst2_pc_wen",   {31'b0, bus.pc_wen},       32'h0);
    chk("rst2_pend",     {31'b0, dut.pend_valid_q}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
